inst_mem_loader: RTL and testbench

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

---
 rtl/inst_mem_loader_if.sv | 27 ++
 rtl/inst_mem_loader.sv | 117 +++++++++++
 tb/tb_inst_mem_loader.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// Signal names match the original loader ports so existing wiring maps one-to-one.
interface inst_mem_loader_if;
   logic        Start;
   logic [13:0] Length;
   logic        Abort;
   logic [7:0]  ByteIn;
   logic        ByteValid;
   logic        ByteReady;
   logic        WriteEn;
   logic [31:0] WriteAdd;
   logic [31:0] WriteData;
   logic        Busy;
   logic        Done;
   logic        Error;
   logic [13:0] WordCount;

   modport master (
      output Start, Length, Abort, ByteIn, ByteValid,
      input  ByteReady, WriteEn, WriteAdd, WriteData, Busy, Done, Error, WordCount
   );

   modport slave (
      input  Start, Length, Abort, ByteIn, ByteValid,
      output ByteReady, WriteEn, WriteAdd, WriteData, Busy, Done, Error, WordCount
   );
endinterface

// File: rtl/inst_mem_loader.sv
// Assembles big-endian 32-bit instruction words from a byte stream and
// writes them to consecutive word addresses of the instruction memory.
module inst_mem_loader #(
   parameter int unsigned MAX_WORDS = 8192
) (
   input logic              clk,
   input logic              rst,
   inst_mem_loader_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, FIN} state_t;

   state_t      state_q, state_d;
   logic [1:0]  bcnt_q, bcnt_d;
   logic [23:0] asm_q, asm_d;
   logic [13:0] len_q, len_d;
   logic [13:0] cnt_q, cnt_d;
   logic [13:0] wadd_q, wadd_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d;

   logic        accept;
   logic        len_zero;
   logic        len_over;
   logic [13:0] cnt_inc;

   assign accept   = (state_q == LOAD) && bus.ByteValid;
   assign len_zero = (bus.Length == '0);
   assign len_over = (32'(bus.Length) > MAX_WORDS);
   assign cnt_inc  = cnt_q + 14'd1;

   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      asm_d   = asm_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      wadd_d  = wadd_q;
      wdata_d = wdata_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.Start) begin
               if (len_over) begin
                  err_d = 1'b1;
               end else begin
                  len_d   = bus.Length;
                  cnt_d   = '0;
                  bcnt_d  = '0;
                  state_d = len_zero ? FIN : LOAD;
               end
            end
         end
         LOAD: begin
            if (bus.Abort) begin
               state_d = IDLE;
            end else if (accept) begin
               asm_d  = {asm_q[15:0], bus.ByteIn};
               bcnt_d = bcnt_q + 2'd1;
               // Word and address are captured here so the write port is purely registered.
               if (bcnt_q == 2'd3) begin
                  wdata_d = {asm_q, bus.ByteIn};
                  wadd_d  = cnt_q;
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            if (bus.Abort) begin
               state_d = IDLE;
            end else begin
               cnt_d   = cnt_inc;
               state_d = (cnt_inc == len_q) ? FIN : LOAD;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         bcnt_q  <= '0;
         asm_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         wadd_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         asm_q   <= asm_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         wadd_q  <= wadd_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   // Abort during WRITE cancels the strobe in the same cycle.
   assign bus.WriteEn   = (state_q == WRITE) && !bus.Abort;
   assign bus.ByteReady = (state_q == LOAD);
   assign bus.Busy      = (state_q != IDLE);
   assign bus.Done      = (state_q == FIN);
   assign bus.Error     = err_q;
   assign bus.WriteAdd  = {18'd0, wadd_q};
   assign bus.WriteData = wdata_q;
   assign bus.WordCount = cnt_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: table of directed loads, reset sequence, and
// randomized loads checked against a word-level model of the byte stream.
module tb_inst_mem_loader;

   localparam int MAXW = 8192;

   typedef struct {
      int len;
      int gap;      // 0 = always valid, 1 = alternate cycles, 2 = random
      int abort_w;  // word index whose 4th byte carries Abort, -1 = none
      bit ex_bytes; // use the fixed example byte stream
      int exp_wr;
      int exp_done;
      int exp_err;
      int exp_wc;
   } vec_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_cmp;
   int   n_bad;

   logic [31:0] wr_add[$];
   logic [31:0] wr_dat[$];
   int          wr_cyc[$];
   int          n_done, n_errp, n_busy, n_ready, done_cyc;
   logic [7:0]  bytes_q[$];
   int          last_wc;

   inst_mem_loader_if m ();

   inst_mem_loader #(.MAX_WORDS(MAXW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Outputs are sampled late in each cycle, after the driver has settled the inputs.
   always @(negedge clk) begin
      #2;
      if (!rst) begin
         if (m.WriteEn) begin
            wr_add.push_back(m.WriteAdd);
            wr_dat.push_back(m.WriteData);
            wr_cyc.push_back(cyc);
         end
         if (m.Done) begin
            n_done++;
            done_cyc = cyc;
         end
         if (m.Error) n_errp++;
         if (m.Busy) n_busy++;
         if (m.ByteReady) n_ready++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_logs();
      wr_add.delete();
      wr_dat.delete();
      wr_cyc.delete();
      n_done = 0;
      n_errp = 0;
      n_busy = 0;
      n_ready = 0;
      done_cyc = -1;
   endtask

   task automatic run_load(input int len, input int gap, input int abort_w, input bit ex_bytes,
                           input bit poke, input int exp_wr, input int exp_done,
                           input int exp_err, input int exp_wc);
      int nbytes, idx, budget, nw;
      bit v, tog, stopped;
      logic [7:0] ex[8];
      logic [31:0] w;
      ex = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08};
      @(negedge clk);
      clear_logs();
      bytes_q.delete();
      nbytes = (len >= 1 && len <= MAXW) ? 4 * len : 0;
      for (int i = 0; i < nbytes; i++)
         bytes_q.push_back((ex_bytes && i < 8) ? ex[i] : 8'($urandom));
      m.Start  = 1'b1;
      m.Length = 14'(len);
      @(negedge clk);
      m.Start = 1'b0;
      idx = 0;
      tog = 1'b1;
      stopped = 1'b0;
      budget = 20 * len + 50;
      while (m.Busy && budget > 0) begin
         case (gap)
            0: v = 1'b1;
            1: begin v = tog; tog = !tog; end
            default: v = 1'($urandom_range(0, 1));
         endcase
         if (stopped || idx >= nbytes) v = 1'b0;
         m.ByteValid = v;
         m.ByteIn    = v ? bytes_q[idx] : 8'($urandom);
         m.Abort     = 1'b0;
         m.Start     = 1'b0;
         if (v && m.ByteReady) begin
            if (abort_w >= 0 && idx == 4 * abort_w + 3) begin
               m.Abort = 1'b1;
               stopped = 1'b1;
            end
            idx++;
         end
         // Start while loading must be ignored.
         if (poke && m.ByteReady && $urandom_range(0, 7) == 0) begin
            m.Start  = 1'b1;
            m.Length = 14'($urandom);
         end
         @(negedge clk);
         budget--;
      end
      m.ByteValid = 1'b0;
      m.Abort = 1'b0;
      m.Start = 1'b0;
      if (budget <= 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL load_timeout: Busy still %0b, expected 0 within budget", m.Busy);
      end
      repeat (2) @(negedge clk);

      chk("n_writes", wr_add.size(), exp_wr);
      nw = (wr_add.size() < exp_wr) ? wr_add.size() : exp_wr;
      for (int k = 0; k < nw; k++) begin
         w = {bytes_q[4*k], bytes_q[4*k+1], bytes_q[4*k+2], bytes_q[4*k+3]};
         chk("wr_add", wr_add[k], k);
         chk("wr_dat", wr_dat[k], w);
         if (gap == 0 && k > 0) chk("wr_spacing", wr_cyc[k] - wr_cyc[k-1], 5);
      end
      chk("done_pulses", n_done, exp_done);
      chk("error_pulses", n_errp, exp_err);
      chk("word_count", m.WordCount, exp_wc);
      chk("busy_after", m.Busy, 0);
      if (nbytes == 0) chk("ready_cycles", n_ready, 0);
      if (len == 0) chk("busy_cycles", n_busy, 1);
      if (nbytes == 0 && len != 0) chk("busy_cycles", n_busy, 0);
      if (exp_wr > 0 && exp_done > 0) chk("last_add", m.WriteAdd, exp_wr - 1);
      if (gap == 0 && exp_done > 0 && exp_wr > 0 && wr_cyc.size() > 0)
         chk("done_latency", done_cyc - wr_cyc[wr_cyc.size()-1], 1);
      last_wc = exp_wc;
   endtask

   vec_t vecs[$];

   initial begin
      int len, gap, ab, e_wr, e_done, e_err, e_wc;
      n_cmp = 0;
      n_bad = 0;
      cyc = 0;
      last_wc = 0;
      clear_logs();
      rst = 1'b1;
      m.Start = 1'b0;
      m.Length = '0;
      m.Abort = 1'b0;
      m.ByteIn = '0;
      m.ByteValid = 1'b0;

      vecs.push_back('{2,     0, -1, 1, 2,    1, 0, 2});
      vecs.push_back('{1,     1, -1, 0, 1,    1, 0, 1});
      vecs.push_back('{0,     0, -1, 0, 0,    1, 0, 0});
      vecs.push_back('{8193,  0, -1, 0, 0,    0, 1, 0});
      vecs.push_back('{5,     0,  3, 0, 3,    0, 0, 3});
      vecs.push_back('{3,     2, -1, 0, 3,    1, 0, 3});
      vecs.push_back('{16383, 0, -1, 0, 0,    0, 1, 3});
      vecs.push_back('{4,     1,  0, 0, 0,    0, 0, 0});
      vecs.push_back('{8192,  0, -1, 0, 8192, 1, 0, 8192});

      repeat (3) @(negedge clk);
      chk("rst_ready", m.ByteReady, 0);
      chk("rst_wen", m.WriteEn, 0);
      chk("rst_wadd", m.WriteAdd, 0);
      chk("rst_wdata", m.WriteData, 0);
      chk("rst_busy", m.Busy, 0);
      chk("rst_done", m.Done, 0);
      chk("rst_error", m.Error, 0);
      chk("rst_wcount", m.WordCount, 0);
      rst = 1'b0;

      foreach (vecs[i])
         run_load(vecs[i].len, vecs[i].gap, vecs[i].abort_w, vecs[i].ex_bytes, 1'b0,
                  vecs[i].exp_wr, vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_wc);

      // Asynchronous reset two bytes into a word.
      @(negedge clk);
      m.Length = 14'd3;
      m.Start = 1'b1;
      @(negedge clk);
      m.Start = 1'b0;
      m.ByteValid = 1'b1;
      m.ByteIn = 8'h11;
      @(negedge clk);
      m.ByteIn = 8'h22;
      @(negedge clk);
      m.ByteValid = 1'b0;
      chk("pre_rst_busy", m.Busy, 1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_ready", m.ByteReady, 0);
      chk("arst_wen", m.WriteEn, 0);
      chk("arst_wadd", m.WriteAdd, 0);
      chk("arst_wdata", m.WriteData, 0);
      chk("arst_busy", m.Busy, 0);
      chk("arst_done", m.Done, 0);
      chk("arst_error", m.Error, 0);
      chk("arst_wcount", m.WordCount, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_logs();
      m.ByteValid = 1'b1;
      m.ByteIn = 8'h33;
      repeat (12) @(negedge clk);
      m.ByteValid = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_writes", wr_add.size(), 0);
      chk("post_rst_busy", n_busy, 0);
      chk("post_rst_done", n_done, 0);
      last_wc = 0;

      for (int it = 0; it < 16; it++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r == 0) len = 0;
         else if (r == 1) len = 8193 + $urandom_range(0, 8190);
         else len = $urandom_range(1, 6);
         gap = $urandom_range(0, 2);
         ab = -1;
         if (len >= 1 && len <= MAXW && $urandom_range(0, 3) == 0) ab = $urandom_range(0, len - 1);
         e_err = 0;
         if (len == 0) begin
            e_wr = 0; e_done = 1; e_wc = 0;
         end else if (len > MAXW) begin
            e_wr = 0; e_done = 0; e_err = 1; e_wc = last_wc;
         end else if (ab >= 0) begin
            e_wr = ab; e_done = 0; e_wc = ab;
         end else begin
            e_wr = len; e_done = 1; e_wc = len;
         end
         run_load(len, gap, ab, 1'b0, 1'b1, e_wr, e_done, e_err, e_wc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
